uart_tx_fifo: RTL and testbench

Byte-oriented UART transmitter with a small input FIFO. It drives the SOC's `TXD` pin, which is currently tied low, and is the transmit counterpart to the `RXD` input. The CPU or any other producer pushes bytes with a valid/ready handshake. The block serialises them as 8N1 frames, LSB first, at a fixed baud rate derived from the system clock.

---
 rtl/uart_tx_fifo.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// ==== uart_tx_fifo : 8N1 UART transmitter fed by a small byte FIFO ====
// ==== Rev 1.0                                                       ====
`default_nettype none

module uart_tx_fifo #(
   parameter int CLK_FREQ_HZ = 10_000_000,
   parameter int BAUD_RATE   = 115_200,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                          CLK,
   input  logic                          RESET,
   input  logic                          wr_valid,
   input  logic [7:0]                    wr_data,
   output logic                          wr_ready,
   output logic                          TXD,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;
   localparam int BW  = $clog2(DIV + 1);

   localparam logic [BW-1:0] BAUD_LAST  = BW'(DIV - 1);
   localparam logic [BW-1:0] BAUD_END   = BW'(DIV);
   localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

   generate
      if (DIV < 2) begin : g_div_check
         $error("uart_tx_fifo: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
      end
      if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
         $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2 and at least 2");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   state_t        state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          txd_q, txd_d;

   logic          w_push;
   logic          w_pop;

   assign wr_ready   = (count_q != COUNT_FULL);
   assign w_push     = wr_valid && wr_ready;
   assign fifo_count = count_q;
   assign busy       = (state_q != IDLE) || (count_q != '0);
   assign TXD        = txd_q;

   always_comb begin
      count_d = count_q;
      if (w_push && !w_pop) begin
         count_d = count_q + CW'(1);
      end else if (!w_push && w_pop) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (w_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      w_pop   = 1'b0;
      txd_d   = 1'b1;

      // The line register follows the state one cycle later.
      case (state_q)
         IDLE:    txd_d = 1'b1;
         START:   txd_d = 1'b0;
         DATA:    txd_d = shift_q[0];
         STOP:    txd_d = 1'b1;
         default: txd_d = 1'b1;
      endcase

      case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               w_pop   = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               baud_d  = '0;
               state_d = START;
            end
         end
         START: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = '0;
               bit_d   = 3'd0;
               state_d = DATA;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         DATA: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         STOP: begin
            // One extra count before IDLE keeps busy high until the
            // registered line has finished the stop bit.
            if ((baud_q >= BAUD_LAST) && (count_q != '0)) begin
               w_pop   = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               baud_d  = '0;
               state_d = START;
            end else if (baud_q == BAUD_END) begin
               baud_d  = '0;
               state_d = IDLE;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            baud_d  = '0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         txd_q   <= txd_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ==== tb_uart_tx_fifo : scoreboard bench for uart_tx_fifo (DIV=10, depth 4) ====
// ==== Rev 1.0                                                               ====
`default_nettype none

module tb_uart_tx_fifo;

   localparam int DIV = 10;

   logic       CLK      = 1'b0;
   logic       RESET    = 1'b1;
   logic       wr_valid = 1'b0;
   logic [7:0] wr_data  = 8'h00;
   logic       wr_ready;
   logic       TXD;
   logic       busy;
   logic [2:0] fifo_count;

   int          n_cmp = 0;
   int          n_err = 0;
   int unsigned cyc   = 0;
   logic        mon_abort = 1'b0;

   logic [7:0]  exp_q [$];
   int unsigned starts [$];

   uart_tx_fifo #(
      .CLK_FREQ_HZ (10_000_000),
      .BAUD_RATE   (1_000_000),
      .FIFO_DEPTH  (4)
   ) u_dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .wr_valid   (wr_valid),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .TXD        (TXD),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic wait_busy_low(input string name, output int n);
      n = 0;
      while (busy !== 1'b0 && n < 2000) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 2000) begin
         chk({name, " timeout"}, 32'd1, 32'd0);
      end
   endtask

   // Monitor: every start bit pops the next expected byte and checks all
   // ten bit windows sample by sample.
   initial begin : monitor
      logic [9:0] fr;
      logic       ok;
      logic       ab;
      logic       badv;
      forever begin
         @(negedge CLK);
         if (TXD === 1'b0 && !mon_abort) begin
            starts.push_back(cyc);
            if (exp_q.size() == 0) begin
               chk("frame unexpected start", 32'd1, 32'd0);
               for (int i = 0; i < 10*DIV - 1; i++) @(negedge CLK);
            end else begin
               fr = {1'b1, exp_q.pop_front(), 1'b0};
               ab = 1'b0;
               for (int b = 0; b < 10 && !ab; b++) begin
                  ok   = 1'b1;
                  badv = 1'b0;
                  for (int s = 0; s < DIV; s++) begin
                     if (b != 0 || s != 0) @(negedge CLK);
                     if (mon_abort) begin
                        ab = 1'b1;
                        break;
                     end
                     if (ok && TXD !== fr[b]) begin
                        ok   = 1'b0;
                        badv = TXD;
                     end
                  end
                  if (!ab) begin
                     chk($sformatf("frame %02h bit%0d", fr[8:1], b),
                         {31'd0, (ok ? fr[b] : badv)}, {31'd0, fr[b]});
                  end
               end
            end
         end
      end
   end

   logic [2:0] bp_cnt [6] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4};

   initial begin : stimulus
      int n;
      repeat (3) @(negedge CLK);
      chk("reset TXD",        TXD,        1);
      chk("reset busy",       busy,       0);
      chk("reset fifo_count", fifo_count, 0);
      chk("reset wr_ready",   wr_ready,   1);
      RESET = 1'b0;
      @(negedge CLK);

      // Single byte 0x55
      exp_q.push_back(8'h55);
      wr_valid = 1'b1; wr_data = 8'h55;
      @(negedge CLK);
      wr_valid = 1'b0;
      chk("single count after push", fifo_count, 1);
      chk("single TXD before pop",   TXD,        1);
      @(negedge CLK);
      chk("single count after pop",  fifo_count, 0);
      chk("single busy after pop",   busy,       1);
      chk("single TXD at pop",       TXD,        1);
      @(negedge CLK);
      chk("single TXD start",        TXD,        0);
      wait_busy_low("single busy", n);
      chk("single busy length", n + 2, 102);

      // Bit order 0x41
      exp_q.push_back(8'h41);
      wr_valid = 1'b1; wr_data = 8'h41;
      @(negedge CLK);
      wr_valid = 1'b0;
      wait_busy_low("bitorder busy", n);
      chk("bitorder busy length", n, 102);

      // Backpressure 0x10..0x15, then a rejected push on the pop cycle
      for (int i = 0; i < 6; i++) exp_q.push_back(8'h10 + 8'(i));
      for (int i = 0; i < 6; i++) begin
         wr_valid = 1'b1; wr_data = 8'h10 + 8'(i);
         chk($sformatf("bp count cycle%0d", i + 1), fifo_count, bp_cnt[i]);
         chk($sformatf("bp ready cycle%0d", i + 1), wr_ready,   (i < 5) ? 1 : 0);
         if (i < 5) @(negedge CLK);
      end
      n = 0;
      while (wr_ready !== 1'b1 && n < 300) begin
         @(negedge CLK);
         n++;
      end
      chk("bp cycles until ready", n, 97);
      @(negedge CLK);
      wr_valid = 1'b0;
      chk("bp count after late accept", fifo_count, 4);
      repeat (98) @(negedge CLK);
      wr_valid = 1'b1; wr_data = 8'hEE;
      chk("full+pop ready",  wr_ready,   0);
      chk("full+pop count",  fifo_count, 4);
      @(negedge CLK);
      wr_valid = 1'b0;
      chk("full+pop count after", fifo_count, 3);
      wait_busy_low("bp drain", n);
      chk("bp drain length", n, 401);

      // Back-to-back three frames
      starts.delete();
      exp_q.push_back(8'hA5); exp_q.push_back(8'h3C); exp_q.push_back(8'hF0);
      wr_valid = 1'b1; wr_data = 8'hA5;
      @(negedge CLK); wr_data = 8'h3C;
      @(negedge CLK); wr_data = 8'hF0;
      @(negedge CLK); wr_valid = 1'b0;
      wait_busy_low("b2b busy", n);
      chk("b2b busy length", n + 2, 302);
      chk("b2b frame count", starts.size(), 3);
      if (starts.size() == 3) begin
         chk("b2b start gap 1", starts[1] - starts[0], 100);
         chk("b2b start gap 2", starts[2] - starts[1], 100);
      end

      // Reset during data bit 3 with two bytes queued
      starts.delete();
      exp_q.push_back(8'h81);
      wr_valid = 1'b1; wr_data = 8'h81;
      @(negedge CLK); wr_data = 8'h42;
      @(negedge CLK); wr_data = 8'h24;
      @(negedge CLK); wr_valid = 1'b0;
      repeat (43) @(negedge CLK);
      chk("rst queued count", fifo_count, 2);
      chk("rst TXD bit3",     TXD,        0);
      mon_abort = 1'b1;
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      chk("rst TXD after",   TXD,        1);
      chk("rst count after", fifo_count, 0);
      chk("rst busy after",  busy,       0);
      exp_q.delete();
      repeat (5) @(negedge CLK);
      mon_abort = 1'b0;
      repeat (250) @(negedge CLK);
      chk("rst stays idle",    busy,          0);
      chk("rst no new frames", starts.size(), 1);

      chk("scoreboard drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
